tt_serial_byte_framer: RTL
==========================

# tt_serial_byte_framer

Upstream feeder for the 8-bit combinational bit-weight checker. It deserialises a framed serial bit stream into bytes, registers each completed byte with its popcount and parity, and exposes the held byte to the pad ring through a 4-bit selectable window. It also provides handshake and error flags so an external host, or the checker stage that consumes the parallel byte, sees only complete, stable words.

## Interface
- No parameters. Frame width is fixed at 8 bits and bit order is MSB first.
- io_in[0]  input  1  clk. The single clock; all state updates on its rising edge.
- io_in[1]  input  1  reset. Synchronous, active-high.
- io_in[2]  input  1  sdata. Serial data bit.
- io_in[3]  input  1  sbit_valid. sdata is sampled on an edge where this is 1.
- io_in[4]  input  1  frame_start. Begins a new frame and zeroes the bit counter.
- io_in[6:5]  input  2  sel. Output window select:
  - 00: held[3:0]
  - 01: held[7:4]
  - 10: popcount
  - 11: {overrun, frame_err, 2'b00}
- io_in[7]  input  1  ack. Host has consumed the held byte.
- io_out[3:0]  output  4  Window chosen by sel. Combinational mux of registered values.
- io_out[4]  output  1  word_ready. One-cycle pulse when a new byte is latched.
- io_out[5]  output  1  parity. XOR of the held byte.
- io_out[6]  output  1  busy. High in SHIFT with bit count ≠ 0.
- io_out[7]  output  1  pending. The held byte has not been acked.

## Operation
- States are IDLE and SHIFT, with a 3-bit bit counter bcnt and an 8-bit shift register sr.
- IDLE:
  - sbit_valid without frame_start is ignored.
  - frame_start moves to SHIFT with bcnt = 0.
  - If sbit_valid is also 1 in that cycle, that bit is taken as bit 7 of the new frame and bcnt = 1.
- SHIFT, on sbit_valid: sr <= {sr[6:0], sdata}, bcnt <= bcnt + 1.
- Byte completion: when the 8th bit is accepted (bcnt == 7 and sbit_valid):
  - held <= {sr[6:0], sdata}.
  - popcount <= ones in that byte, range 0..8, 4 bits.
  - parity <= its XOR.
  - word_ready pulses and pending <= 1.
  - bcnt wraps to 0 and the state stays SHIFT, so back-to-back frames need no new frame_start.
- frame_start in SHIFT with bcnt ≠ 0: the partial word is discarded, frame_err <= 1 (sticky) and bcnt restarts at 0. A same-cycle sbit_valid bit is taken as the first bit of the new frame.
- frame_start in SHIFT with bcnt == 0 is legal and sets no flag.
- Overrun: if a byte completes while pending == 1 and ack == 0, the new byte overwrites held and overrun <= 1 (sticky).
- Ack handling:
  - ack clears pending.
  - ack in the same cycle as a completion: pending stays 1 and there is no overrun.
  - ack while sel == 11 additionally clears overrun and frame_err.
- held, popcount and parity change only on completion. They remain stable otherwise, including across frame_err.
- reset sets the following, overriding any same-cycle input:
  - state = IDLE
  - bcnt = 0, sr = 0, held = 0, popcount = 0, parity = 0
  - word_ready = 0, pending = 0, overrun = 0, frame_err = 0

## Timing
- All outputs except the io_out[3:0] mux are registered. The mux follows sel combinationally, with no cycle delay.
- Latency: held, popcount, parity, pending and word_ready are all visible in the cycle after the edge that samples the 8th bit.
- word_ready lasts exactly one cycle per completed byte. Consecutive bytes need at least 8 sampling edges, so pulses are at least 8 cycles apart.
- Minimum frame is 8 consecutive cycles with sbit_valid = 1. Gaps in sbit_valid are allowed and only stall the bit counter.
- Reset asserted mid-frame: the partial word is lost, and the next cycle shows every output at its reset value.

## Test plan
- Basic frame: reset, then frame_start together with sbit_valid and bits 1,0,1,0,0,1,0,1 over 8 cycles. Required next cycle: word_ready = 1 for 1 cycle, pending = 1, parity = 0. Windows: sel = 00 gives 0x5, sel = 01 gives 0xA, sel = 10 gives 0x4.
- Back-to-back frames: 0xFF then 0x07 with no second frame_start. Required:
  - popcount 8 (io_out[3:0] = 1000), parity 0.
  - Then popcount 3, parity 1.
  - Two word_ready pulses, 8 cycles apart.
- Overrun: send 0x3C without ack, then 0x81. Required: held = 0x81, overrun = 1, and the window at sel = 11 reads 1000. Then ack with sel = 11 gives pending = 0 and the window reads 0000.
- Frame error: after 3 bits, assert frame_start, then send a full 0x12. Required: frame_err = 1, held = 0x12, popcount = 2, and held unchanged before completion.
- Ack/completion collision and stalls: with pending = 1, send 0x55 with sbit_valid gaps, and assert ack on the completing edge. Required: pending = 1, overrun = 0, held = 0x55, popcount = 4.
- Reset mid-frame: assert reset after 5 bits. Required: all outputs 0 the next cycle, and sbit_valid without frame_start is ignored afterwards.

Source files
------------

// File: rtl/tt_serial_byte_framer.sv
// Serial-to-parallel byte framer: deserialises MSB-first frames, holds each completed
// byte with its popcount and parity, and exposes it through a 4-bit selectable window.
module tt_serial_byte_framer (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  logic       clk;
  logic       reset;
  logic       sdata;
  logic       sbit_valid;
  logic       frame_start;
  logic [1:0] sel;
  logic       ack;

  assign clk         = io_in[0];
  assign reset       = io_in[1];
  assign sdata       = io_in[2];
  assign sbit_valid  = io_in[3];
  assign frame_start = io_in[4];
  assign sel         = io_in[6:5];
  assign ack         = io_in[7];

  logic       state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] held_q, held_d;
  logic [3:0] popcount_q, popcount_d;
  logic       parity_q, parity_d;
  logic       word_ready_q, word_ready_d;
  logic       pending_q, pending_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  logic [7:0] next_byte;
  logic [3:0] window;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  assign next_byte = {sr_q[6:0], sdata};

  // Ack clears are applied first so that a same-cycle completion re-asserts pending.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    sr_d         = sr_q;
    held_d       = held_q;
    popcount_d   = popcount_q;
    parity_d     = parity_q;
    word_ready_d = 1'b0;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;

    if (ack) begin
      pending_d = 1'b0;
      if (sel == 2'b11) begin
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
      end
    end

    if (frame_start) begin
      if (state_q == STATE_SHIFT && bcnt_q != 3'd0) begin
        frame_err_d = 1'b1;
      end
      state_d = STATE_SHIFT;
      bcnt_d  = 3'd0;
      if (sbit_valid) begin
        sr_d   = next_byte;
        bcnt_d = 3'd1;
      end
    end else if (state_q == STATE_SHIFT && sbit_valid) begin
      sr_d   = next_byte;
      bcnt_d = bcnt_q + 3'd1;
      if (bcnt_q == 3'd7) begin
        held_d       = next_byte;
        popcount_d   = count_ones(next_byte);
        parity_d     = ^next_byte;
        word_ready_d = 1'b1;
        pending_d    = 1'b1;
        if (pending_q && !ack) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= STATE_IDLE;
      bcnt_q       <= 3'd0;
      sr_q         <= 8'd0;
      held_q       <= 8'd0;
      popcount_q   <= 4'd0;
      parity_q     <= 1'b0;
      word_ready_q <= 1'b0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      sr_q         <= sr_d;
      held_q       <= held_d;
      popcount_q   <= popcount_d;
      parity_q     <= parity_d;
      word_ready_q <= word_ready_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    window = 4'd0;
    case (sel)
      2'b00:   window = held_q[3:0];
      2'b01:   window = held_q[7:4];
      2'b10:   window = popcount_q;
      default: window = {overrun_q, frame_err_q, 2'b00};
    endcase
  end

  assign io_out = {pending_q,
                   (state_q == STATE_SHIFT) && (bcnt_q != 3'd0),
                   parity_q,
                   word_ready_q,
                   window};

endmodule
